// File: rtl/wb_sdram_arbiter.sv
// rtl/wb_sdram_arbiter.sv - two-master Wishbone classic arbiter for the SDRAM controller port
// Round-robin grant held for a whole CYC, plus a stall watchdog that forces ERR.
module wb_sdram_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam bit WD_ON = (TIMEOUT > 0);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic          last_nxt;
  logic [CW-1:0] wd_count;
  logic          stb_req;
  logic          wd_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // last names the most recent winner (0 = m0, 1 = m1); on a tie the other master wins
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last) begin
            state_nxt = G0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = G1;
            last_nxt  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_nxt = G0;
          last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = G1;
          last_nxt  = 1'b1;
        end
      end
      G0:      if (!m0_cyc_i) state_nxt = IDLE;
      G1:      if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_o = {state == G1, state == G0};

  assign s_adr_o = grant_o[1] ? m1_adr_i : m0_adr_i;
  assign s_dat_o = grant_o[1] ? m1_dat_i : m0_dat_i;
  assign s_sel_o = grant_o[1] ? m1_sel_i : m0_sel_i;
  assign s_we_o  = grant_o[1] ? m1_we_i  : m0_we_i;
  assign s_cyc_o = (grant_o[0] & m0_cyc_i) | (grant_o[1] & m1_cyc_i);
  assign stb_req = (grant_o[0] & m0_stb_i) | (grant_o[1] & m1_stb_i);

  // ack and err beat the timeout when they arrive in the same cycle
  assign wd_err  = WD_ON && stb_req && !s_ack_i && !s_err_i && (wd_count == WD_LAST);
  assign s_stb_o = stb_req & ~wd_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_count <= '0;
    end else if (!WD_ON || (state_nxt != state) || (grant_o == 2'b00) ||
                 s_ack_i || s_err_i || wd_err) begin
      wd_count <= '0;
    end else if (stb_req) begin
      wd_count <= wd_count + CW'(1);
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & grant_o[0] & m0_stb_i;
  assign m1_ack_o = s_ack_i & grant_o[1] & m1_stb_i;
  assign m0_err_o = (s_err_i & grant_o[0] & m0_stb_i) | (wd_err & grant_o[0]);
  assign m1_err_o = (s_err_i & grant_o[1] & m1_stb_i) | (wd_err & grant_o[1]);

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb/tb_wb_sdram_arbiter.sv - directed self-checking bench for wb_sdram_arbiter
// Two instances share all inputs: watchdog at 16 cycles and watchdog disabled.
module tb_wb_sdram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat, s_rdat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack, s_err;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]  grant_o;

  logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
  logic [3:0]  z_s_sel_o;
  logic        z_m0_ack_o, z_m0_err_o, z_m1_ack_o, z_m1_err_o, z_s_we_o, z_s_cyc_o, z_s_stb_o;
  logic [1:0]  z_grant_o;

  int checks = 0;
  int errors = 0;
  int bad;
  int bad0;
  int nerr;

  always #5 clock = ~clock;

  wb_sdram_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_rdat), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_o)
  );

  wb_sdram_arbiter #(.AW(32), .DW(32), .TIMEOUT(0)) dut_nowd (
    .clock(clock), .reset(reset),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(z_m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(z_m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o),
    .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_dat_i(s_rdat), .s_sel_o(z_s_sel_o), .s_we_o(z_s_we_o),
    .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(z_grant_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m0_adr = '0; m0_wdat = '0; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_wdat = '0; m1_sel = 4'hF; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
    repeat (2) tick();
    check("rst_grant", grant_o, 2'b00);
    check("rst_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    check("rst_ack_err", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
    reset = 1'b0;

    // single m0 read, slave acks on the third strobe cycle
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
    #1;
    check("t1_latency", grant_o, 2'b00);
    tick();
    check("t1_grant", grant_o, 2'b01);
    check("t1_adr", s_adr_o, 32'h0000_0100);
    check("t1_stb", s_stb_o, 1'b1);
    tick();
    check("t1_noack", m0_ack_o, 1'b0);
    tick();
    s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    #1;
    check("t1_ack", m0_ack_o, 1'b1);
    check("t1_rdata", m0_dat_o, 32'hDEAD_BEEF);
    check("t1_m1_ack", m1_ack_o, 1'b0);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    check("t1_ack_pulse", m0_ack_o, 1'b0);
    check("t1_hold", grant_o, 2'b01);
    tick();
    check("t1_idle", grant_o, 2'b00);

    // simultaneous requests after reset alternate strictly
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      tick();
      check($sformatf("rr%0d_grant", r), grant_o, (r % 2 == 0) ? 2'b01 : 2'b10);
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      tick();
      check($sformatf("rr%0d_idle", r), grant_o, 2'b00);
    end

    // m1 four-beat write burst while m0 waits
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_0200;
    tick();
    check("burst_grant", grant_o, 2'b10);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m1_wdat = 32'hA000 + b;
      s_ack = 1'b1;
      #1;
      check($sformatf("burst%0d_m1ack", b), m1_ack_o, 1'b1);
      check($sformatf("burst%0d_dat", b), s_dat_o, 32'hA000 + b);
      check($sformatf("burst%0d_m0ack", b), m0_ack_o, 1'b0);
      check($sformatf("burst%0d_grant", b), grant_o, 2'b10);
      tick();
    end
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    #1;
    check("burst_release_hold", grant_o, 2'b10);
    tick();
    check("burst_idle", grant_o, 2'b00);
    tick();
    check("burst_m0_next", grant_o, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // watchdog: slave never answers
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0300;
    tick();
    check("wd_stb_rise", s_stb_o, 1'b1);
    bad = 0; bad0 = 0;
    for (int i = 1; i < 15; i++) begin
      tick();
      if (m0_err_o !== 1'b0) bad++;
      if (z_m0_err_o !== 1'b0) bad0++;
    end
    check("wd_no_early_err", bad, 0);
    tick();
    check("wd_err", m0_err_o, 1'b1);
    check("wd_stb_cut", s_stb_o, 1'b0);
    check("nowd_no_err", z_m0_err_o, 1'b0);
    check("nowd_stb", z_s_stb_o, 1'b1);
    tick();
    m0_stb = 1'b0; s_ack = 1'b1;
    #1;
    check("wd_stray_ack", m0_ack_o, 1'b0);
    check("wd_err_once", m0_err_o, 1'b0);
    s_ack = 1'b0;

    // ack landing on the timeout cycle wins
    m0_cyc = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    repeat (14) tick();
    tick();
    s_ack = 1'b1;
    #1;
    check("late_ack", m0_ack_o, 1'b1);
    check("late_no_err", m0_err_o, 1'b0);
    check("nowd_late_ack", z_m0_ack_o, 1'b1);
    tick();
    s_ack = 1'b0;
    nerr = 0; bad0 = bad0 + 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m0_err_o === 1'b1) nerr++;
      if (z_m0_err_o !== 1'b0) bad0++;
    end
    check("wd_repeat_count", nerr, 2);
    check("nowd_never_err", bad0, 0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    // reset during beat 2 of an m1 burst
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    tick();
    check("rb_grant", grant_o, 2'b10);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    reset = 1'b1;
    #1;
    check("rb_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    check("rb_grant_clr", grant_o, 2'b00);
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    tick();
    reset = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    check("rb_idle", grant_o, 2'b00);
    tick();
    check("rb_m0_grant", grant_o, 2'b01);
    check("rb_m0_stb", s_stb_o, 1'b1);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
